// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared combinational ALU; multiplies occupy it for MUL_LAT cycles.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins ties and the round-robin pointer is removed.
//
// state | meaning
// IDLE  | waiting for a request; ready asserted to the granted requester
// EXEC  | single-cycle ALU op driven from latched operands, result captured
// MUL   | multiply held on the ALU for MUL_LAT cycles, result captured on last
// RESP  | response presented until rsp_ready_i
module alu_share_arb #(
  parameter int DW      = 32,
  parameter int MUL_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_valid_i,
  input  logic          req1_valid_i,
  output logic          req0_ready_o,
  output logic          req1_ready_o,
  input  logic [3:0]    req0_op_i,
  input  logic [3:0]    req1_op_i,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  output logic [3:0]    alu_ctrl_o,
  output logic [DW-1:0] alu_src1_o,
  output logic [DW-1:0] alu_src2_o,
  input  logic [DW-1:0] alu_result_i,
  input  logic          alu_zero_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic          rsp_id_o,
  output logic [DW-1:0] rsp_result_o,
  output logic          rsp_zero_o
);

  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q;
  logic [DW-1:0] a_q, b_q;
  logic          id_q;
  logic [3:0]    cnt_q;
  logic [DW-1:0] res_q;
  logic          zero_q;

  logic          grant_1;
  logic          accept;
  logic [3:0]    sel_op;
  logic          capture;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant_1 = req1_valid_i & ~req0_valid_i;
`else
  logic prio_q;
  // prio_q names the requester that wins a tie
  assign grant_1 = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
`endif

  assign accept  = (state_q == S_IDLE) & (req0_valid_i | req1_valid_i) & ~rst_i;
  assign sel_op  = grant_1 ? req1_op_i : req0_op_i;
  assign capture = (state_q == S_EXEC) | ((state_q == S_MUL) & (cnt_q == 4'd0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= sel_op;
        a_q   <= grant_1 ? req1_a_i : req0_a_i;
        b_q   <= grant_1 ? req1_b_i : req0_b_i;
        id_q  <= grant_1;
        cnt_q <= CNT_INIT;
      end else if ((state_q == S_MUL) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        res_q  <= alu_result_i;
        zero_q <= alu_zero_i;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (accept) begin
      prio_q <= ~grant_1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (sel_op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_MUL:  if (cnt_q == 4'd0) state_d = S_RESP;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    alu_ctrl_o   = '0;
    alu_src1_o   = '0;
    alu_src2_o   = '0;
    rsp_valid_o  = 1'b0;
    rsp_id_o     = 1'b0;
    rsp_result_o = '0;
    rsp_zero_o   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready_o = accept & ~grant_1 & req0_valid_i;
        req1_ready_o = accept &  grant_1 & req1_valid_i;
      end
      S_EXEC, S_MUL: begin
        alu_ctrl_o = op_q;
        alu_src1_o = a_q;
        alu_src2_o = b_q;
      end
      S_RESP: begin
        rsp_valid_o  = 1'b1;
        rsp_id_o     = id_q;
        rsp_result_o = res_q;
        rsp_zero_o   = zero_q;
      end
      default: ;
    endcase
  end

endmodule
